// File: rtl/mux2_arbiter_pkg.sv
// rtl/mux2_arbiter_pkg.sv - state type and helpers for the 2-requester burst arbiter
//
// Purpose: wraps the raw encodings from mux2_arb_defs.vh in a typed enum so
// the arbiter and anything observing it agree on the state values.
// Ports: none (package).
package mux2_arbiter_pkg;

`include "mux2_arb_defs.vh"

  typedef enum logic [1:0] {
    IDLE = `MUX2_ARB_IDLE,
    GNT0 = `MUX2_ARB_GNT0,
    GNT1 = `MUX2_ARB_GNT1
  } state_t;

  // Grant state that belongs to requester k.
  function automatic state_t gnt_state(input logic k);
    return k ? GNT1 : GNT0;
  endfunction

endpackage

// File: rtl/mux2_arb_defs.vh
// rtl/mux2_arb_defs.vh - state encodings shared by the arbiter and its bench
`ifndef MUX2_ARB_DEFS_VH
`define MUX2_ARB_DEFS_VH

`define MUX2_ARB_IDLE 2'd0
`define MUX2_ARB_GNT0 2'd1
`define MUX2_ARB_GNT1 2'd2

`endif

// File: rtl/mux2x1_w.sv
// rtl/mux2x1_w.sv - WIDTH-wide 2:1 word multiplexer
//
// Purpose: purely combinational word select, y = s ? a1 : a0.
// Ports:
//   s  - select (0 = a0, 1 = a1)
//   a0 - word from requester 0
//   a1 - word from requester 1
//   y  - selected word
module mux2x1_w #(
  parameter int WIDTH = 8
) (
  input  logic             s,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  output logic [WIDTH-1:0] y
);

  assign y = s ? a1 : a0;

endmodule

// File: rtl/mux2_arbiter.sv
// rtl/mux2_arbiter.sv - two-requester burst arbiter onto one shared channel
//
// Purpose: grants the shared channel to one requester for a whole burst
// (until a transfer carrying last), alternating priority under contention.
// Data is passed through combinationally, never registered.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   a0_valid/a0_data/a0_last      - requester 0 offer
//   a0_ready                      - requester 0 word accepted this cycle
//   a1_valid/a1_data/a1_last      - requester 1 offer
//   a1_ready                      - requester 1 word accepted this cycle
//   y_valid/y_data/y_last         - shared output channel
//   y_ready                       - downstream accepts y_data this cycle
//   s                             - current mux select (held while idle)
//   busy                          - a grant is held
module mux2_arbiter
  import mux2_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a0_valid,
  input  logic [WIDTH-1:0] a0_data,
  input  logic             a0_last,
  output logic             a0_ready,
  input  logic             a1_valid,
  input  logic [WIDTH-1:0] a1_data,
  input  logic             a1_last,
  output logic             a1_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             y_last,
  input  logic             y_ready,
  output logic             s,
  output logic             busy
);

  state_t state;
  logic   prio;
  logic   gnt0;
  logic   gnt1;
  logic   pick;
  logic   xfer_last;

  assign gnt0 = (state == GNT0);
  assign gnt1 = (state == GNT1);

  // With a single requester it wins outright; with both, prio decides.
  assign pick = (a0_valid && a1_valid) ? prio : a1_valid;

  assign busy     = gnt0 | gnt1;
  assign y_valid  = (gnt0 & a0_valid) | (gnt1 & a1_valid);
  // Gated by the grant so y_last reads 0 while idle.
  assign y_last   = (gnt0 & a0_last)  | (gnt1 & a1_last);
  assign a0_ready = gnt0 & y_ready;
  assign a1_ready = gnt1 & y_ready;

  assign xfer_last = y_valid & y_ready & y_last;

  mux2x1_w #(
    .WIDTH(WIDTH)
  ) u_mux (
    .s (s),
    .a0(a0_data),
    .a1(a1_data),
    .y (y_data)
  );

  // s is loaded on the way into a grant, so inside GNTk it already equals k
  // and the data path needs no decode of the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio  <= 1'b0;
      s     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (a0_valid || a1_valid) begin
            state <= gnt_state(pick);
            s     <= pick;
          end
        end
        GNT0, GNT1: begin
          // Only a completed last transfer releases the grant; in GNTk s == k,
          // so the other requester is ~s.
          if (xfer_last) begin
            state <= IDLE;
            prio  <= ~s;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
